clock_divider_multi: RTL and testbench
======================================

Name: clock_divider_multi

Overview:
Multi-channel programmable clock divider, the parametrised successor of the single fixed-factor divider. Each channel derives a divided clock-enable waveform and a one-cycle period strobe from clk_i. Divisor and high time are runtime-programmable per channel, and updates are glitch-free: a new setting takes effect only at a period boundary. It feeds PWM, serial-bit-rate and sampling logic across the board.

Parameters:
CHANNELS, 4, number of independent divider channels (1..16)
WIDTH, 16, bit width of counter, divisor and high-time registers
DEFAULT_DIV, 2, divisor loaded into every channel at reset (2 .. 2^WIDTH-1)

Ports:
clk_i  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
enable_i  in  CHANNELS  per-channel run enable, level-sensitive
load_i  in  1  single-cycle load strobe
load_ch_i  in  max(1,$clog2(CHANNELS))  target channel for load
load_div_i  in  WIDTH  new divisor (period in clk_i cycles)
load_high_i  in  WIDTH  new high time in clk_i cycles
clk_o  out  CHANNELS  divided waveform, registered
tick_o  out  CHANNELS  one-cycle strobe on last cycle of each period, registered
pending_o  out  CHANNELS  shadow setting waiting for period boundary
err_o  out  1  sticky: an invalid load was rejected

Behaviour:
- Per channel: active div/high/count registers (WIDTH bits, unsigned), plus shadow div/high and a pending flag.
- Reset (async, immediate, no clock needed):
  - clk_o=0, tick_o=0, pending_o=0, err_o=0, count=0.
  - div=DEFAULT_DIV, high=DEFAULT_DIV>>1.
- Enabled channel, each edge (uses pre-edge count):
  - clk_o <= (count >= div-high).
  - tick_o <= (count == div-1).
  - count <= (count == div-1) ? 0 : count+1.
- Waveform shape: low for div-high cycles, then high for high cycles. The waveform and tick lag count by one cycle. tick_o coincides with the final high cycle.
- Disabled channel (enable_i=0):
  - Next edge: count<=0, clk_o<=0, tick_o<=0.
  - Re-enable restarts from count 0 with a full low phase. No partial or runt pulse.
- Load validity: a load is valid iff load_ch_i<CHANNELS, load_div_i>=2 and 1<=load_high_i<=load_div_i-1.
  - Invalid load: err_o<=1 (sticky until reset). No channel state changes.
- Valid load: shadow <= inputs and pending <= 1 for that channel. A second load before the boundary overwrites the shadow (last wins).
- Boundary apply (enabled channel, edge where count==div-1 and pending):
  - div/high <= shadow; count <= 0; pending <= 0.
  - The tick for the ending period is still issued.
- If a valid load targets a channel on its boundary edge, the load values are applied directly at that edge and pending stays 0.
- Disabled channel with pending: apply on the next edge and clear pending.
- Channels are fully independent. Loads to one channel never perturb another.
- Max divisor 2^WIDTH-1. Comparisons are unsigned, and div-high cannot underflow because loads are validated.

Test Plan:
1. Reset release, enable_i=4'b0001, defaults (div=2): clk_o[0] = 0,1,0,1…; tick_o[0] high on every clk_o[0] high cycle; other channels stay 0.
2. Ch1 running div=2; load ch1 div=5 high=2 mid-period:
   - pending_o[1]=1 until boundary.
   - Then clk_o[1] = 0,0,0,1,1 repeating, tick on 5th cycle.
   - No pulse shorter than 1 low/1 high.
3. Invalid loads (div=1; high=0; high=div=6; load_ch_i=CHANNELS with CHANNELS=3): err_o=1 thereafter, pending_o and waveforms unchanged.
4. Ch2 div=4 high=2, enable_i[2] dropped during high phase: clk_o[2]=0 next edge. Re-enable after 3 cycles gives 0,0,1,1 from restart.
5. Two loads to ch0 (div=8 high=1, then div=3 high=1) before boundary: only div=3 high=1 takes effect (0,0,1).
6. Async reset asserted between clock edges with pending set: all outputs 0 immediately. After release, div=DEFAULT_DIV waveform resumes with err_o=0.

Source files
------------

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: per-channel divided waveform plus end-of-period tick,
// with shadowed div/high settings that only take effect on a period boundary.
module clock_divider_multi #(
   parameter int CHANNELS    = 4,
   parameter int WIDTH       = 16,
   parameter int DEFAULT_DIV = 2
) (
   input  logic                                              clk_i,
   input  logic                                              reset,
   input  logic [CHANNELS-1:0]                               enable_i,
   input  logic                                              load_i,
   input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] load_ch_i,
   input  logic [WIDTH-1:0]                                  load_div_i,
   input  logic [WIDTH-1:0]                                  load_high_i,
   output logic [CHANNELS-1:0]                               clk_o,
   output logic [CHANNELS-1:0]                               tick_o,
   output logic [CHANNELS-1:0]                               pending_o,
   output logic                                              err_o
);

   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [WIDTH-1:0] DEF_DIV  = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] DEF_HIGH = DEF_DIV >> 1;
   localparam logic [CH_W:0]    CH_LIM   = (CH_W + 1)'(CHANNELS);

   logic [WIDTH-1:0]    div_q     [CHANNELS];
   logic [WIDTH-1:0]    high_q    [CHANNELS];
   logic [WIDTH-1:0]    count_q   [CHANNELS];
   logic [WIDTH-1:0]    sh_div_q  [CHANNELS];
   logic [WIDTH-1:0]    sh_high_q [CHANNELS];
   logic [CHANNELS-1:0] pending_q;
   logic [CHANNELS-1:0] clk_q;
   logic [CHANNELS-1:0] tick_q;
   logic                err_q;

   logic                load_ok;
   logic [CHANNELS-1:0] hit;
   logic [CHANNELS-1:0] last;
   logic [CHANNELS-1:0] above;

   // high < div together with high != 0 guarantees div-high never underflows
   always_comb begin
      load_ok = ({1'b0, load_ch_i} < CH_LIM) && (load_div_i >= WIDTH'(2)) &&
                (load_high_i != '0) && (load_high_i < load_div_i);
      hit   = '0;
      last  = '0;
      above = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         hit[c]   = load_i && load_ok && (load_ch_i == CH_W'(c));
         last[c]  = (count_q[c] == (div_q[c] - WIDTH'(1)));
         above[c] = (count_q[c] >= (div_q[c] - high_q[c]));
      end
   end

   always_ff @(posedge clk_i or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < CHANNELS; c++) begin
            div_q[c]     <= DEF_DIV;
            high_q[c]    <= DEF_HIGH;
            count_q[c]   <= '0;
            sh_div_q[c]  <= DEF_DIV;
            sh_high_q[c] <= DEF_HIGH;
         end
         pending_q <= '0;
         clk_q     <= '0;
         tick_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         if (load_i && !load_ok) begin
            err_q <= 1'b1;
         end
         for (int c = 0; c < CHANNELS; c++) begin
            if (enable_i[c]) begin
               clk_q[c]  <= above[c];
               tick_q[c] <= last[c];
               if (last[c]) begin
                  count_q[c] <= '0;
                  if (hit[c]) begin
                     div_q[c]     <= load_div_i;
                     high_q[c]    <= load_high_i;
                     pending_q[c] <= 1'b0;
                  end else if (pending_q[c]) begin
                     div_q[c]     <= sh_div_q[c];
                     high_q[c]    <= sh_high_q[c];
                     pending_q[c] <= 1'b0;
                  end
               end else begin
                  count_q[c] <= count_q[c] + WIDTH'(1);
                  if (hit[c]) begin
                     sh_div_q[c]  <= load_div_i;
                     sh_high_q[c] <= load_high_i;
                     pending_q[c] <= 1'b1;
                  end
               end
            end else begin
               count_q[c] <= '0;
               clk_q[c]   <= 1'b0;
               tick_q[c]  <= 1'b0;
               if (pending_q[c]) begin
                  div_q[c]     <= sh_div_q[c];
                  high_q[c]    <= sh_high_q[c];
                  pending_q[c] <= 1'b0;
               end
               // a load arriving while idle is held and applied on the following edge
               if (hit[c]) begin
                  sh_div_q[c]  <= load_div_i;
                  sh_high_q[c] <= load_high_i;
                  pending_q[c] <= 1'b1;
               end
            end
         end
      end
   end

   assign clk_o     = clk_q;
   assign tick_o    = tick_q;
   assign pending_o = pending_q;
   assign err_o     = err_q;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi (3 channels): expected {pending,clk,tick} per cycle is queued
// ahead of each stimulus phase and popped as the DUT produces each edge's outputs.
module tb_clock_divider_multi;

   localparam int CH = 3;
   localparam int W  = 16;

   logic          clk_i = 1'b0;
   logic          reset = 1'b0;
   logic [CH-1:0] enable_i = '0;
   logic          load_i = 1'b0;
   logic [1:0]    load_ch_i = '0;
   logic [W-1:0]  load_div_i = '0;
   logic [W-1:0]  load_high_i = '0;
   logic [CH-1:0] clk_o;
   logic [CH-1:0] tick_o;
   logic [CH-1:0] pending_o;
   logic          err_o;

   int         checks = 0;
   int         failures = 0;
   int         sb_idx = 0;
   string      cur_tag = "init";
   logic [2:0] exp_q [$];

   clock_divider_multi #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(2)) dut (
      .clk_i      (clk_i),
      .reset      (reset),
      .enable_i   (enable_i),
      .load_i     (load_i),
      .load_ch_i  (load_ch_i),
      .load_div_i (load_div_i),
      .load_high_i(load_high_i),
      .clk_o      (clk_o),
      .tick_o     (tick_o),
      .pending_o  (pending_o),
      .err_o      (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", tag, act, exp_v);
      end
   endtask

   task automatic push(input logic [2:0] v);
      exp_q.push_back(v);
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // one edge, then compare {pending,clk,tick} of channel ch against the queue head
   task automatic step_sb(input int ch);
      logic [2:0] e;
      step();
      sb_idx++;
      if (exp_q.size() == 0) begin
         check($sformatf("%s_empty_%0d", cur_tag, sb_idx), 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check($sformatf("%s_%0d", cur_tag, sb_idx),
               {29'd0, pending_o[ch], clk_o[ch], tick_o[ch]}, {29'd0, e});
      end
   endtask

   task automatic set_load(input logic [1:0] ch, input int dv, input int hi);
      load_i      = 1'b1;
      load_ch_i   = ch;
      load_div_i  = W'(dv);
      load_high_i = W'(hi);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      #1 reset = 1'b1;
      #1;
      check("rst_clk",  {29'd0, clk_o},     32'd0);
      check("rst_tick", {29'd0, tick_o},    32'd0);
      check("rst_pend", {29'd0, pending_o}, 32'd0);
      check("rst_err",  {31'd0, err_o},     32'd0);
      step();
      reset    = 1'b0;
      enable_i = 3'b001;

      // default div=2: clk 0,1,... with tick on each high cycle
      cur_tag = "t1_ch0";
      for (int i = 0; i < 3; i++) begin
         push(3'b000);
         push(3'b011);
      end
      repeat (6) step_sb(0);
      check("t1_other", {28'd0, clk_o[2:1], tick_o[2:1]}, 32'd0);

      // ch1 at div=2, then div=5 high=2 loaded while count=0
      cur_tag  = "t2_ch1";
      enable_i = 3'b011;
      push(3'b000); push(3'b011);
      push(3'b100); push(3'b011);
      for (int p = 0; p < 2; p++) begin
         push(3'b000); push(3'b000); push(3'b000); push(3'b010); push(3'b011);
      end
      step_sb(1);
      step_sb(1);
      set_load(2'd1, 5, 2);
      step_sb(1);
      load_i = 1'b0;
      repeat (11) step_sb(1);
      check("t3_err_before", {31'd0, err_o}, 32'd0);

      // invalid loads must not disturb ch1
      cur_tag = "t3_ch1";
      push(3'b000); push(3'b000); push(3'b000); push(3'b010); push(3'b011);
      set_load(2'd1, 1, 1);
      step_sb(1);
      check("t3_err_set", {31'd0, err_o}, 32'd1);
      set_load(2'd1, 5, 0);
      step_sb(1);
      set_load(2'd1, 6, 6);
      step_sb(1);
      set_load(2'd3, 5, 2);
      step_sb(1);
      load_i = 1'b0;
      step_sb(1);
      check("t3_err_sticky", {31'd0, err_o},     32'd1);
      check("t3_pend",       {29'd0, pending_o}, 32'd0);

      // ch2 div=4 high=2 loaded while idle, enable dropped in high phase
      cur_tag = "t4_ch2";
      push(3'b100); push(3'b000);
      push(3'b000); push(3'b000); push(3'b010);
      push(3'b000); push(3'b000); push(3'b000);
      push(3'b000); push(3'b000); push(3'b010); push(3'b011);
      set_load(2'd2, 4, 2);
      step_sb(2);
      load_i = 1'b0;
      step_sb(2);
      enable_i[2] = 1'b1;
      repeat (3) step_sb(2);
      enable_i[2] = 1'b0;
      repeat (3) step_sb(2);
      enable_i[2] = 1'b1;
      repeat (4) step_sb(2);

      // ch0: div=4 high=2, then two loads before the boundary, last one wins
      cur_tag = "t5_ch0";
      push(3'b100); push(3'b000);
      push(3'b000); push(3'b100); push(3'b110); push(3'b011);
      for (int p = 0; p < 2; p++) begin
         push(3'b000); push(3'b000); push(3'b011);
      end
      enable_i[0] = 1'b0;
      set_load(2'd0, 4, 2);
      step_sb(0);
      load_i = 1'b0;
      step_sb(0);
      enable_i[0] = 1'b1;
      step_sb(0);
      set_load(2'd0, 8, 1);
      step_sb(0);
      set_load(2'd0, 3, 1);
      step_sb(0);
      load_i = 1'b0;
      repeat (7) step_sb(0);

      // async reset mid-cycle with a pending setting
      enable_i = 3'b000;
      set_load(2'd1, 7, 3);
      step();
      load_i = 1'b0;
      check("t6_pend_set", {29'd0, pending_o}, 32'd2);
      #3 reset = 1'b1;
      #1;
      check("t6_rst_clk",  {29'd0, clk_o},     32'd0);
      check("t6_rst_tick", {29'd0, tick_o},    32'd0);
      check("t6_rst_pend", {29'd0, pending_o}, 32'd0);
      check("t6_rst_err",  {31'd0, err_o},     32'd0);
      step();
      reset    = 1'b0;
      enable_i = 3'b001;
      cur_tag  = "t6_ch0";
      push(3'b000); push(3'b011); push(3'b000); push(3'b011);
      repeat (4) step_sb(0);
      check("t6_err_after", {31'd0, err_o}, 32'd0);
      check("sb_drain", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
